// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states, frame width and idle line levels.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        HIGH   = 3'd2,
        LOW    = 3'd3,
        FINISH = 3'd4
    } spi_state_e;

    localparam int   SPI_FRAME_BITS = 8;
    localparam logic SPI_SCLK_IDLE  = 1'b0;
    localparam logic SPI_MOSI_IDLE  = 1'b1;
    localparam logic SPI_SS_IDLE    = 1'b1;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer: reloaded on each phase entry, flags the last cycle of the phase.
module spi_half_period_timer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expire
);

    localparam int            CW     = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};

    logic [CW-1:0] cnt_r;

    // Count down from CLK_DIV-1 after a load; rest at zero between phases
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= ZERO;
        end else if (load) begin
            cnt_r <= RELOAD;
        end else if (cnt_r != ZERO) begin
            cnt_r <= cnt_r - CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == ZERO);

endmodule

// File: rtl/spi_master_8bit.sv
// Full-duplex LSB-first 8-bit SPI master with trailing sclk pulses for the slave's
// frame-completion logic; all outputs are registered from the next-state decode.
module spi_master_8bit
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int TAIL_CLKS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       miso,
    output logic       sclk,
    output logic       ss,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data
);

    localparam logic [3:0] PULSES      = 4'(SPI_FRAME_BITS + TAIL_CLKS);
    localparam logic [3:0] DATA_PULSES = 4'(SPI_FRAME_BITS);

    spi_state_e state_r, state_nxt_s;
    logic       expire_s, load_s;
    logic [3:0] pulse_r, pulse_nxt_s;
    logic [7:0] tx_shift_r, tx_shift_nxt_s;
    logic [7:0] rx_shift_r, rx_shift_nxt_s;
    logic [7:0] rx_data_r, rx_data_nxt_s;
    logic       mosi_r, mosi_nxt_s;
    logic       sclk_r, ss_r, busy_r, done_r;
    logic       sclk_nxt_s, ss_nxt_s, busy_nxt_s, done_nxt_s;

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_s),
        .expire  (expire_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, shift and output decode; the timer reloads on every state change
    always_comb begin
        state_nxt_s    = state_r;
        load_s         = 1'b0;
        pulse_nxt_s    = pulse_r;
        tx_shift_nxt_s = tx_shift_r;
        rx_shift_nxt_s = rx_shift_r;
        rx_data_nxt_s  = rx_data_r;
        mosi_nxt_s     = mosi_r;
        done_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s    = LEAD;
                    load_s         = 1'b1;
                    pulse_nxt_s    = 4'd0;
                    tx_shift_nxt_s = tx_data;
                    rx_shift_nxt_s = 8'h00;
                    mosi_nxt_s     = tx_data[0];
                end else begin
                    state_nxt_s = IDLE;
                    mosi_nxt_s  = SPI_MOSI_IDLE;
                end
            end
            LEAD: begin
                if (expire_s) begin
                    state_nxt_s = HIGH;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = LEAD;
                end
            end
            HIGH: begin
                if (expire_s) begin
                    state_nxt_s    = LOW;
                    load_s         = 1'b1;
                    pulse_nxt_s    = pulse_r + 4'd1;
                    // Ones shift in behind the data so tail pulses drive mosi high
                    tx_shift_nxt_s = {SPI_MOSI_IDLE, tx_shift_r[7:1]};
                    mosi_nxt_s     = tx_shift_r[1];
                    if (pulse_r < DATA_PULSES) begin
                        rx_shift_nxt_s = {miso, rx_shift_r[7:1]};
                    end else begin
                        rx_shift_nxt_s = rx_shift_r;
                    end
                end else begin
                    state_nxt_s = HIGH;
                end
            end
            LOW: begin
                if (expire_s) begin
                    load_s = 1'b1;
                    if (pulse_r < PULSES) begin
                        state_nxt_s = HIGH;
                    end else begin
                        state_nxt_s = FINISH;
                        mosi_nxt_s  = SPI_MOSI_IDLE;
                    end
                end else begin
                    state_nxt_s = LOW;
                end
            end
            FINISH: begin
                if (expire_s) begin
                    state_nxt_s   = IDLE;
                    load_s        = 1'b1;
                    rx_data_nxt_s = rx_shift_r;
                    done_nxt_s    = 1'b1;
                    mosi_nxt_s    = SPI_MOSI_IDLE;
                end else begin
                    state_nxt_s = FINISH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                mosi_nxt_s  = SPI_MOSI_IDLE;
            end
        endcase
        sclk_nxt_s = (state_nxt_s == HIGH) ? ~SPI_SCLK_IDLE : SPI_SCLK_IDLE;
        ss_nxt_s   = ((state_nxt_s == IDLE) || (state_nxt_s == FINISH)) ? SPI_SS_IDLE : ~SPI_SS_IDLE;
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Datapath and registered output stage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pulse_r    <= 4'd0;
            tx_shift_r <= 8'h00;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            mosi_r     <= SPI_MOSI_IDLE;
            sclk_r     <= SPI_SCLK_IDLE;
            ss_r       <= SPI_SS_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            pulse_r    <= pulse_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            mosi_r     <= mosi_nxt_s;
            sclk_r     <= sclk_nxt_s;
            ss_r       <= ss_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign sclk    = sclk_r;
    assign ss      = ss_r;
    assign mosi    = mosi_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;

endmodule

// File: tb/tb_spi_master_8bit.sv
// Directed bench for spi_master_8bit: default instance plus a CLK_DIV=1, TAIL_CLKS=0 instance.
module tb_spi_master_8bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n_a, start_a, miso_a, sclk_a, ss_a, mosi_a, busy_a, done_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       reset_n_b, start_b, miso_b, sclk_b, ss_b, mosi_b, busy_b, done_b;
    logic [7:0] tx_data_b, rx_data_b;

    spi_master_8bit u_a (
        .clk(clk), .reset_n(reset_n_a), .start(start_a), .tx_data(tx_data_a), .miso(miso_a),
        .sclk(sclk_a), .ss(ss_a), .mosi(mosi_a), .busy(busy_a), .done(done_a), .rx_data(rx_data_a)
    );

    spi_master_8bit #(.CLK_DIV(1), .TAIL_CLKS(0)) u_b (
        .clk(clk), .reset_n(reset_n_b), .start(start_b), .tx_data(tx_data_b), .miso(miso_b),
        .sclk(sclk_b), .ss(ss_b), .mosi(mosi_b), .busy(busy_b), .done(done_b), .rx_data(rx_data_b)
    );

    int         n_total = 0;
    int         n_bad   = 0;
    logic       ss_log   [0:127];
    logic       sclk_log [0:127];
    logic       mosi_log [0:127];
    logic       busy_log [0:127];
    logic [7:0] rx_log   [0:127];
    int         done_cyc, done_cyc2, n_done, rises, rise0, rise1;
    logic [9:0] mosi_bits;
    logic [7:0] rx_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame on the default instance; cycle 0 is the cycle start is first high.
    task automatic frame_a(input logic [7:0] tx, input logic [7:0] sbyte, input bit jitter,
                           input int hold_start, input int restart_cyc, input int rst_cyc,
                           input int ncyc);
        logic prev_sclk;
        int   k;
        done_cyc = -1; done_cyc2 = -1; n_done = 0; rises = 0;
        mosi_bits = 10'h000; rx_done = 8'h00; prev_sclk = 1'b0;
        @(negedge clk);
        start_a = 1'b1; tx_data_a = tx;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c < 128) begin
                ss_log[c] = ss_a; sclk_log[c] = sclk_a; mosi_log[c] = mosi_a;
                busy_log[c] = busy_a; rx_log[c] = rx_data_a;
            end
            if (done_a) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c; rx_done = rx_data_a;
                end else if (done_cyc2 < 0) begin
                    done_cyc2 = c;
                end
            end
            if (!ss_a && sclk_a && !prev_sclk) begin
                if (rises < 10) mosi_bits[rises] = mosi_a;
                k = rises;
                rises++;
                if (k < 8) miso_a = jitter ? ~sbyte[k] : sbyte[k];
                else       miso_a = jitter ? ~miso_a : 1'b1;
            end else if (!ss_a && sclk_a) begin
                k = rises - 1;
                if (k < 8) miso_a = sbyte[k];
                else       miso_a = jitter ? ~miso_a : 1'b1;
            end
            prev_sclk = sclk_a;
            start_a = (c < hold_start) ? 1'b1 : 1'b0;
            if (c == restart_cyc) begin
                start_a = 1'b1; tx_data_a = 8'h00;
            end
            reset_n_a = (c == rst_cyc) ? 1'b0 : 1'b1;
        end
        start_a = 1'b0;
    endtask

    // One frame on the fast instance with miso held constant.
    task automatic frame_b(input logic miso_val, input int ncyc);
        logic prev_sclk;
        done_cyc = -1; rises = 0; rise0 = -1; rise1 = -1; rx_done = 8'h00; prev_sclk = 1'b0;
        mosi_bits = 10'h000;
        miso_b = miso_val;
        @(negedge clk);
        start_b = 1'b1; tx_data_b = 8'hFF;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (done_b && done_cyc < 0) begin
                done_cyc = c; rx_done = rx_data_b;
            end
            if (!ss_b && sclk_b && !prev_sclk) begin
                if (rises < 10) mosi_bits[rises] = mosi_b;
                if (rises == 0) rise0 = c;
                if (rises == 1) rise1 = c;
                rises++;
            end
            prev_sclk = sclk_b;
        end
    endtask

    initial begin
        reset_n_a = 1'b0; start_a = 1'b0; miso_a = 1'b0; tx_data_a = 8'h00;
        reset_n_b = 1'b0; start_b = 1'b0; miso_b = 1'b0; tx_data_b = 8'h00;
        repeat (3) @(negedge clk);
        reset_n_a = 1'b1; reset_n_b = 1'b1;
        @(negedge clk);
        chk("rst_ss",   {31'd0, ss_a},   32'd1);
        chk("rst_sclk", {31'd0, sclk_a}, 32'd0);
        chk("rst_mosi", {31'd0, mosi_a}, 32'd1);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_rx",   {24'd0, rx_data_a}, 32'h00);

        // Default frame: A5 out, 3C back
        frame_a(8'hA5, 8'h3C, 1'b0, 1, -1, -1, 50);
        chk("a5_done_cyc", done_cyc, 32'd45);
        chk("a5_rx",       {24'd0, rx_done}, 32'h3C);
        chk("a5_mosi",     {22'd0, mosi_bits}, 32'h3A5);
        chk("a5_rises",    rises, 32'd10);
        chk("a5_ndone",    n_done, 32'd1);
        chk("a5_busy1",    {31'd0, busy_log[1]},  32'd1);
        chk("a5_busy44",   {31'd0, busy_log[44]}, 32'd1);
        chk("a5_busy45",   {31'd0, busy_log[45]}, 32'd0);
        chk("a5_lead_ss",  {31'd0, ss_log[1]},    32'd0);
        chk("a5_lead_clk", {31'd0, sclk_log[2]},  32'd0);
        chk("a5_p0_high",  {31'd0, sclk_log[3]},  32'd1);
        chk("a5_fin_mosi", {31'd0, mosi_log[43]}, 32'd1);

        // Fast instance: miso=1 then miso=0
        frame_b(1'b1, 25);
        chk("b1_rx", {24'd0, rx_done}, 32'hFF);
        frame_b(1'b0, 25);
        chk("b0_done_cyc", done_cyc, 32'd19);
        chk("b0_rx",       {24'd0, rx_done}, 32'h00);
        chk("b0_rise0",    rise0, 32'd2);
        chk("b0_period",   rise1 - rise0, 32'd2);
        chk("b0_rises",    rises, 32'd8);
        chk("b0_mosi",     {22'd0, mosi_bits}, 32'h0FF);

        // Start held high: back-to-back frames
        frame_a(8'hA5, 8'h3C, 1'b0, 60, -1, -1, 100);
        chk("hold_done1", done_cyc, 32'd45);
        chk("hold_done2", done_cyc2, 32'd90);
        chk("hold_ss42",  {31'd0, ss_log[42]}, 32'd0);
        chk("hold_ss43",  {31'd0, ss_log[43]}, 32'd1);
        chk("hold_ss45",  {31'd0, ss_log[45]}, 32'd1);
        chk("hold_ss46",  {31'd0, ss_log[46]}, 32'd0);
        chk("hold_ndone", n_done, 32'd2);

        // Start mid-frame is ignored
        frame_a(8'hA5, 8'h3C, 1'b0, 1, 10, -1, 50);
        chk("mid_mosi",  {22'd0, mosi_bits}, 32'h3A5);
        chk("mid_ndone", n_done, 32'd1);
        chk("mid_done",  done_cyc, 32'd45);

        // Reset mid-frame, then a clean frame
        frame_a(8'hA5, 8'h3C, 1'b0, 1, -1, 20, 50);
        chk("abort_ss20", {31'd0, ss_log[20]},   32'd0);
        chk("abort_ss",   {31'd0, ss_log[21]},   32'd1);
        chk("abort_sclk", {31'd0, sclk_log[21]}, 32'd0);
        chk("abort_mosi", {31'd0, mosi_log[21]}, 32'd1);
        chk("abort_busy", {31'd0, busy_log[21]}, 32'd0);
        chk("abort_rx",   {24'd0, rx_log[21]},   32'h00);
        chk("abort_ndone", n_done, 32'd0);
        frame_a(8'hA5, 8'h3C, 1'b0, 1, -1, -1, 50);
        chk("post_done", done_cyc, 32'd45);
        chk("post_rx",   {24'd0, rx_done}, 32'h3C);

        // miso glitches while sclk high, noisy tail
        frame_a(8'h5A, 8'h96, 1'b1, 1, -1, -1, 50);
        chk("jit_rx",   {24'd0, rx_done}, 32'h96);
        chk("jit_mosi", {22'd0, mosi_bits}, 32'h35A);
        chk("jit_done", done_cyc, 32'd45);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
